img_stream_loader: RTL and testbench
====================================

# img_stream_loader

Front-end loader that receives the input image as a 16-bit word stream and packs it into full 5120-bit rows (640 pixels × 8 bits) for the 480-row original-image SRAM. It drives that memory's write port while the top-level FSM is in its idle/load phase. It then signals frame completion so the Gaussian stage can start reading rows.

## Interface
Parameters:
- COLS, 640: pixels per row (8-bit each); row width = 8*COLS = 5120 bits; beats per row = COLS/2 = 320
- ROWS, 480: rows per frame; address width 9

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  qualifies in_data; one beat per cycle when high, gaps allowed
- in_data  in  16  two pixels per beat: [7:0] = even column, [15:8] = odd column
- clear  in  1  synchronous soft reset; discards any partial frame
- img_we  out  1  write strobe to original-image SRAM, one-cycle pulse per row
- img_addr  out  9  row address for the write (0..479)
- img_din  out  5120  packed row; column c at bits [8c+7:8c]
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after the last row is written
- frame_err  out  1  sticky; stream beat arrived while the loader could not accept it

## Operation
- Counters: col_cnt 0..319 (beats within row), row_cnt 0..479.
- Packing: a 5120-bit shift register. Each accepted beat shifts right by 16 and inserts in_data at [5119:5104]. After 320 beats, beat 0 sits at [15:0], which gives column c at [8c+7:8c].
- Row commit: on the accepting edge of beat 319, copy the shift-register contents *including that beat* into the img_din capture register. Set img_addr = row_cnt and img_we = 1 for the next cycle. col_cnt wraps to 0 and row_cnt increments. The shift register is free immediately, so back-to-back rows need no stall.
- States:
  - IDLE: in_valid=1 → the beat is accepted as row 0, beat 0 → LOAD.
  - LOAD: accepts beats. Beat 319 of row 479 → FLUSH.
  - FLUSH: the last row's img_we is asserted → DONE.
  - DONE: done=1 → IDLE.
- in_valid in FLUSH or DONE: the beat is dropped and frame_err is set. In IDLE, in_valid always starts a new frame.
- frame_err clears only on rst_n or clear.
- clear: state → IDLE, both counters 0, img_we/done 0, frame_err 0. The shift register and img_din are not required to clear. clear has priority over a simultaneous in_valid, and that beat is dropped without setting frame_err.
- Asynchronous reset mid-frame has the same effect as clear, and also zeroes img_din, img_addr and the shift register. No partial-row write is ever issued.

## Timing
- Reset values: img_we=0, img_addr=0, img_din=0, busy=0, done=0, frame_err=0, state=IDLE.
- Latency: final beat of row r accepted at edge t → img_we=1, img_addr=r, img_din valid during cycle t..t+1. img_we drops the following cycle unless another row completes.
- img_din and img_addr hold their values until the next row commit.
- Last row: final beat at edge t → FLUSH with img_we=1 in cycle t+1. done=1 in cycle t+2, so the write has landed before done. busy falls with done's falling edge.
- Minimum frame length: 153600 accepted beats. Minimum IDLE-to-done: 153602 cycles with continuous in_valid.
- in_valid gaps of any length inside a row or between rows are allowed. Counters advance only on accepted beats.
- At most one img_we per 320 accepted beats, so consecutive strobes are at least 320 cycles apart.

## Test plan
- Continuous frame, pixel(row,col) = (row+col)&0xFF → 480 img_we pulses with addr 0..479. Row 5 img_din[7:0]=0x05 and [5119:5112]=0x84. done exactly 2 cycles after the last beat. frame_err=0.
- Same frame with a random 30% in_valid duty, including gaps straddling row boundaries → identical SRAM contents, and img_we timing is the cycle after each 320th accepted beat.
- Two frames back-to-back, with the second frame's first beat in the cycle after done → second frame's row 0 is written at addr 0, and frame_err stays 0.
- Beat presented during FLUSH → the beat is dropped, frame_err=1 and stays set through the next frame until clear.
- clear asserted together with in_valid at beat 100 of row 7 → no img_we for row 7. busy=0 next cycle. The next frame starts at row 0 and produces correct contents.
- rst_n low asynchronously mid-row 200 → all outputs zero immediately without waiting for a clock edge. After release, a full frame loads correctly.

Source files
------------

// File: rtl/img_stream_loader.sv
// Packs a 16-bit pixel-pair stream into full image rows and writes them to the original-image SRAM.
// One write strobe per completed row; done pulses two cycles after the last beat of the frame.
module img_stream_loader #(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int W  = 8 * COLS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  input  logic          clear,
  output logic          img_we,
  output logic [AW-1:0] img_addr,
  output logic [W-1:0]  img_din,
  output logic          busy,
  output logic          done,
  output logic          frame_err
);

  localparam int BEATS = COLS / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t          state;
  logic [W-1:0]    sr;
  logic [W-1:0]    sr_next;
  logic [CW-1:0]   col_cnt;
  logic [AW-1:0]   row_cnt;
  logic            accept;
  logic            last_beat;
  logic            last_row;

  assign accept    = in_valid && ((state == IDLE) || (state == LOAD));
  assign sr_next   = {in_data, sr[W-1:16]};
  assign last_beat = (col_cnt == CW'(BEATS - 1));
  assign last_row  = (row_cnt == AW'(ROWS - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      img_we    <= 1'b0;
      img_addr  <= '0;
      img_din   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      img_we    <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      img_we <= 1'b0;
      done   <= 1'b0;
      if (in_valid && !accept)
        frame_err <= 1'b1;
      if (accept) begin
        sr <= sr_next;
        if (last_beat) begin
          // Capture includes the beat arriving now, freeing sr for the next row at once.
          col_cnt  <= '0;
          img_din  <= sr_next;
          img_addr <= row_cnt;
          img_we   <= 1'b1;
          if (last_row) begin
            row_cnt <= '0;
            state   <= FLUSH;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= LOAD;
          end
        end else begin
          col_cnt <= col_cnt + 1'b1;
          state   <= LOAD;
        end
      end else begin
        case (state)
          FLUSH: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_stream_loader.sv
// Randomized bench for img_stream_loader on a reduced 16x6 image, checked every cycle against a pixel-level model.
module tb_img_stream_loader;
  localparam int COLS = 16;
  localparam int ROWS = 6;
  localparam int B    = COLS / 2;
  localparam int W    = 8 * COLS;
  localparam int AW   = $clog2(ROWS);
  localparam int FB   = B * ROWS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = '0;
  logic          clear = 1'b0;
  logic          img_we;
  logic [AW-1:0] img_addr;
  logic [W-1:0]  img_din;
  logic          busy;
  logic          done;
  logic          frame_err;

  img_stream_loader #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .img_we(img_we), .img_addr(img_addr), .img_din(img_din),
    .busy(busy), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counts accepted beats in the frame, plus a two-cycle tail after the final row.
  int            m_nb = 0;
  int            m_tail = 0;
  logic          m_we = 0, m_done = 0, m_err = 0, m_busy = 0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_din = '0;
  logic [7:0]    m_pix [COLS];
  logic [W-1:0]  m_mem [ROWS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nb = 0; m_tail = 0; m_we = 0; m_done = 0; m_err = 0; m_addr = '0; m_din = '0;
    end else if (clear) begin
      m_nb = 0; m_tail = 0; m_we = 0; m_done = 0; m_err = 0;
    end else begin
      m_we = 0;
      m_done = 0;
      if (m_tail == 2) begin
        m_tail = 1;
        m_done = 1;
        if (in_valid) m_err = 1;
      end else if (m_tail == 1) begin
        m_tail = 0;
        if (in_valid) m_err = 1;
      end else if (in_valid) begin
        m_pix[(m_nb % B) * 2]     = in_data[7:0];
        m_pix[(m_nb % B) * 2 + 1] = in_data[15:8];
        m_nb++;
        if (m_nb % B == 0) begin
          m_we = 1;
          m_addr = AW'(m_nb / B - 1);
          for (int c = 0; c < COLS; c++) m_din[8*c +: 8] = m_pix[c];
          m_mem[m_nb / B - 1] = m_din;
          if (m_nb == FB) begin
            m_nb = 0;
            m_tail = 2;
          end
        end
      end
    end
    m_busy = (m_nb != 0) || (m_tail != 0);
  end

  logic [W-1:0] dut_mem [ROWS];
  int n_we = 0;

  always @(negedge clk) begin
    if (img_we === 1'b1) begin
      dut_mem[img_addr] = img_din;
      n_we++;
    end
    if (chk_en) begin
      chk("img_we",    W'(img_we),    W'(m_we));
      chk("img_addr",  W'(img_addr),  W'(m_addr));
      chk("img_din",   img_din,       m_din);
      chk("busy",      W'(busy),      W'(m_busy));
      chk("done",      W'(done),      W'(m_done));
      chk("frame_err", W'(frame_err), W'(m_err));
    end
  end

  task automatic step(input logic v, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    if (mode == 0) return 8'(r + c);
    return 8'($urandom);
  endfunction

  // Sends the first cnt beats of a frame, inserting idle cycles so the valid duty is about duty%.
  task automatic send_beats(input int mode, input int duty, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      while ($urandom_range(99) >= duty) step(1'b0, 16'h0);
      step(1'b1, {pix(mode, k / B, 2 * (k % B) + 1), pix(mode, k / B, 2 * (k % B))});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic do_clear(input logic v);
    @(negedge clk);
    clear = 1'b1;
    in_valid = v;
    in_data = 16'($urandom);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_golden(input string nm);
    logic [W-1:0] g;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) g[8*c +: 8] = 8'(r + c);
      chk(nm, dut_mem[r], g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    #1 rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    chk("rst_we",   W'(img_we),    W'(1'b0));
    chk("rst_addr", W'(img_addr),  W'(0));
    chk("rst_din",  img_din,       W'(0));
    chk("rst_busy", W'(busy),      W'(1'b0));
    chk("rst_done", W'(done),      W'(1'b0));
    chk("rst_err",  W'(frame_err), W'(1'b0));
    rst_n = 1'b1;
    idle(2);

    // Continuous frame with pixel = row+col
    base = n_we;
    send_beats(0, 100, FB);
    step(1'b0, 16'h0);
    chk("last_we",   W'(img_we), W'(1'b1));
    chk("last_addr", W'(img_addr), W'(ROWS - 1));
    chk("last_done_early", W'(done), W'(1'b0));
    step(1'b0, 16'h0);
    chk("done_at_2", W'(done), W'(1'b1));
    chk("busy_in_done", W'(busy), W'(1'b1));
    step(1'b0, 16'h0);
    chk("done_fall", W'(done), W'(1'b0));
    chk("busy_fall", W'(busy), W'(1'b0));
    chk("we_count1", W'(n_we - base), W'(ROWS));
    chk("row5_lo",   W'(dut_mem[5][7:0]), W'(8'h05));
    chk("row5_hi",   W'(dut_mem[5][W-1 -: 8]), W'(8'h14));
    chk("model5_lo", W'(m_mem[5][7:0]), W'(8'h05));
    chk("model5_hi", W'(m_mem[5][W-1 -: 8]), W'(8'h14));
    chk("err1", W'(frame_err), W'(1'b0));
    check_golden("mem_cont");

    // Same frame with ~30% valid duty
    base = n_we;
    send_beats(0, 30, FB);
    idle(4);
    chk("we_count2", W'(n_we - base), W'(ROWS));
    check_golden("mem_gappy");

    // Back-to-back frames, second starting the cycle after done
    send_beats(1, 100, FB);
    step(1'b0, 16'h0);
    step(1'b0, 16'h0);
    send_beats(1, 100, FB);
    idle(4);
    chk("err_b2b", W'(frame_err), W'(1'b0));
    chk("b2b_row0", dut_mem[0], m_mem[0]);

    // Beat during FLUSH is dropped and frame_err sticks
    send_beats(0, 100, FB);
    step(1'b1, 16'hABCD);
    idle(4);
    chk("err_flush", W'(frame_err), W'(1'b1));
    send_beats(1, 50, FB);
    idle(4);
    chk("err_sticky", W'(frame_err), W'(1'b1));
    do_clear(1'b0);
    chk("err_cleared", W'(frame_err), W'(1'b0));

    // clear together with a beat in the middle of row 3
    base = n_we;
    send_beats(0, 60, 3 * B + 3);
    do_clear(1'b1);
    chk("clr_busy", W'(busy), W'(1'b0));
    chk("clr_err",  W'(frame_err), W'(1'b0));
    idle(3);
    chk("clr_we_count", W'(n_we - base), W'(3));
    base = n_we;
    send_beats(0, 70, FB);
    idle(4);
    chk("we_count_clr", W'(n_we - base), W'(ROWS));
    check_golden("mem_after_clear");

    // Asynchronous reset in the middle of row 4
    send_beats(0, 80, 4 * B + 2);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_we",   W'(img_we),    W'(1'b0));
    chk("arst_addr", W'(img_addr),  W'(0));
    chk("arst_din",  img_din,       W'(0));
    chk("arst_busy", W'(busy),      W'(1'b0));
    chk("arst_done", W'(done),      W'(1'b0));
    chk("arst_err",  W'(frame_err), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    base = n_we;
    send_beats(0, 100, FB);
    idle(4);
    chk("we_count_arst", W'(n_we - base), W'(ROWS));
    check_golden("mem_after_arst");

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
